// File: rtl/cmp_pkg.sv
// Shared state encoding and parameter check for the serial comparator.
// Illegal code 2'd3 is left unused and recovers to ST_IDLE.
`ifndef CMP_PKG_SV
`define CMP_PKG_SV

`define CMP_WIDTH_CHECK(W) \
  if ((((W) % 2) != 0) || ((W) < 2)) begin : g_width_bad \
    $error("serial_cmp_ctrl: WIDTH must be even and >= 2"); \
  end

package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`endif

// File: rtl/comparator.sv
// 2-bit unsigned slice comparator.
// Exactly one of Eq/Less/Greater is high.
module comparator (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       Eq,
  output logic       Less,
  output logic       Greater
);

  assign Eq      = (a == b);
  assign Less    = (a <  b);
  assign Greater = (a >  b);

endmodule

// File: rtl/serial_cmp_ctrl.sv
// MSB-first serial compare of two WIDTH-bit operands
// using one 2-bit slice, stopping at the first unequal slice.
import cmp_pkg::*;

module serial_cmp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             Eq,
  output logic             Less,
  output logic             Greater
);

  localparam int NSLICE = WIDTH / 2;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

  `CMP_WIDTH_CHECK(WIDTH)

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;

  logic [1:0] sa, sb;
  logic       s_eq, s_lt, s_gt;

  assign sa = a_q[{idx_q, 1'b0} +: 2];
  assign sb = b_q[{idx_q, 1'b0} +: 2];

  comparator u_slice (
    .a       (sa),
    .b       (sb),
    .Eq      (s_eq),
    .Less    (s_lt),
    .Greater (s_gt)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IDX_TOP;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!s_eq) begin
          eq_d    = 1'b0;
          lt_d    = s_lt;
          gt_d    = s_gt;
          state_d = ST_DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= IDX_TOP;
      a_q     <= '0;
      b_q     <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
    end
  end

  assign start_ready = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign Eq          = eq_q;
  assign Less        = lt_q;
  assign Greater     = gt_q;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Bench for serial_cmp_ctrl: WIDTH=8 and WIDTH=2 builds
// checked against an arithmetic reference model.
module tb_serial_cmp_ctrl;

  localparam int NS8 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       sv8, sr8, busy8, done8, eq8, lt8, gt8;
  logic [7:0] a8, b8;
  logic       sv2, sr2, busy2, done2, eq2, lt2, gt2;
  logic [1:0] a2, b2;

  int errors = 0;
  int checks = 0;
  logic [2:0] prev;

  serial_cmp_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .start_valid(sv8), .start_ready(sr8),
    .a(a8), .b(b8),
    .busy(busy8), .done(done8),
    .Eq(eq8), .Less(lt8), .Greater(gt8)
  );

  serial_cmp_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst),
    .start_valid(sv2), .start_ready(sr2),
    .a(a2), .b(b2),
    .busy(busy2), .done(done2),
    .Eq(eq2), .Less(lt2), .Greater(gt2)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flags {Eq,Less,Greater} and slices examined, from plain arithmetic.
  task automatic model(input logic [7:0] x, input logic [7:0] y,
                       output int k, output logic [2:0] f);
    int p;
    logic [7:0] d;
    d = x ^ y;
    p = -1;
    for (int i = 0; i < 8; i++)
      if (d[i]) p = i;
    if (p < 0) begin
      k = NS8;
      f = 3'b100;
    end else begin
      k = NS8 - p / 2;
      f = (x < y) ? 3'b010 : 3'b001;
    end
  endtask

  task automatic wait_done8(input string tag, input logic [2:0] expf,
                            input int expk);
    int n = 0;
    while (done8 !== 1'b1 && n < 20) begin
      check({tag, ":busy"}, busy8, 1);
      check({tag, ":ready_run"}, sr8, 0);
      check({tag, ":flags_stable"}, {eq8, lt8, gt8}, prev);
      @(negedge clk);
      n++;
    end
    check({tag, ":latency"}, n, expk);
    check({tag, ":flags"}, {eq8, lt8, gt8}, expf);
    check({tag, ":busy_done"}, busy8, 0);
    prev = expf;
  endtask

  task automatic do_op(input string tag, input logic [7:0] x,
                       input logic [7:0] y, input bit hold);
    int k;
    logic [2:0] f;
    model(x, y, k, f);
    check({tag, ":ready"}, sr8, 1);
    sv8 = 1'b1; a8 = x; b8 = y;
    @(negedge clk);
    if (hold) a8 = 8'hFF;
    else sv8 = 1'b0;
    wait_done8(tag, f, k);
    @(negedge clk);
    check({tag, ":pulse"}, done8, 0);
    check({tag, ":ready_after"}, sr8, 1);
    check({tag, ":no_early_accept"}, busy8, 0);
    if (hold) begin
      @(negedge clk);
      check({tag, ":second_accept"}, busy8, 1);
      sv8 = 1'b0;
      model(8'hFF, y, k, f);
      wait_done8({tag, "_2"}, f, k);
      @(negedge clk);
      check({tag, "_2:pulse"}, done8, 0);
    end
  endtask

  initial begin
    logic [7:0] rx, ry;
    logic [1:0] x2, y2;
    rst = 1'b1;
    sv8 = 1'b0; a8 = '0; b8 = '0;
    sv2 = 1'b0; a2 = '0; b2 = '0;
    prev = 3'b000;
    repeat (2) @(negedge clk);
    check("rst:ready", sr8, 1);
    check("rst:busy", busy8, 0);
    check("rst:done", done8, 0);
    check("rst:flags", {eq8, lt8, gt8}, 3'b000);
    check("rst2:ready", sr2, 1);
    check("rst2:flags", {eq2, lt2, gt2}, 3'b000);
    rst = 1'b0;
    @(negedge clk);

    do_op("c0_40", 8'hC0, 8'h40, 1'b0);
    do_op("12_13", 8'h12, 8'h13, 1'b0);
    do_op("a5_a5", 8'hA5, 8'hA5, 1'b0);
    do_op("hold", 8'h12, 8'h34, 1'b1);

    // Reset in the second RUN cycle discards the op.
    sv8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
    @(negedge clk);
    sv8 = 1'b0;
    check("mid_rst:run1", busy8, 1);
    @(negedge clk);
    check("mid_rst:run2", busy8, 1);
    check("mid_rst:nodone", done8, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst:ready", sr8, 1);
    check("mid_rst:busy", busy8, 0);
    check("mid_rst:done", done8, 0);
    check("mid_rst:flags", {eq8, lt8, gt8}, 3'b000);
    prev = 3'b000;
    do_op("80_7f", 8'h80, 8'h7F, 1'b0);

    // Reset wins over a same-edge start.
    sv8 = 1'b1; a8 = 8'h55; b8 = 8'hAA; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; sv8 = 1'b0;
    check("rst_prio:busy", busy8, 0);
    check("rst_prio:ready", sr8, 1);
    check("rst_prio:flags", {eq8, lt8, gt8}, 3'b000);
    prev = 3'b000;

    for (int i = 0; i < 40; i++) begin
      rx = 8'($urandom);
      case ($urandom_range(0, 2))
        0: ry = 8'($urandom);
        1: ry = rx;
        default: ry = rx ^ (8'h01 << $urandom_range(0, 7));
      endcase
      do_op($sformatf("rnd%0d", i), rx, ry, 1'b0);
    end

    for (int i = 0; i < 16; i++) begin
      x2 = 2'(i >> 2);
      y2 = 2'(i);
      check($sformatf("w2_%0d:ready", i), sr2, 1);
      sv2 = 1'b1; a2 = x2; b2 = y2;
      @(negedge clk);
      sv2 = 1'b0;
      check($sformatf("w2_%0d:busy", i), busy2, 1);
      @(negedge clk);
      check($sformatf("w2_%0d:done", i), done2, 1);
      check($sformatf("w2_%0d:flags", i), {eq2, lt2, gt2},
            {x2 == y2, x2 < y2, x2 > y2});
      @(negedge clk);
      check($sformatf("w2_%0d:pulse", i), done2, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
